axi_slave_mem_model: RTL and testbench
======================================

Name: axi_slave_mem_model

Overview:
- Parametrised AXI4 slave memory model with one read channel set and one write channel set.
- Serves instruction and data memory for core-level benches; two instances hang off the core's instruction and data AXI masters.
- Successor to the fixed slave BFM:
  - configurable data width, depth and ID width;
  - programmable read/write latency to exercise the core's MEM_WAIT stall path;
  - INCR/FIXED bursts with byte strobes.
- Storage is a word array named ram_array, preloadable hierarchically by the bench.

Parameters:
- C_AXI_DATA_WIDTH, 32: data bus width in bits; 32, 64 or 128.
- C_OFFSET_WIDTH, 28: address width in bits.
- C_AXI_ID_WIDTH, 1: ID width.
- C_MEM_DEPTH, 2048: number of words in ram_array; power of two.
- C_RD_LATENCY, 2: cycles from AR handshake to first RVALID; 0..15.
- C_WR_LATENCY, 1: cycles from last W handshake to BVALID; 0..15.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- S_AXI_ARID  in  C_AXI_ID_WIDTH  read ID.
- S_AXI_ARADDR  in  C_OFFSET_WIDTH  read byte address.
- S_AXI_ARLEN  in  8  beats minus 1.
- S_AXI_ARBURST  in  2  burst type.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address handshake.
- S_AXI_RID  out  C_AXI_ID_WIDTH  echoed ARID.
- S_AXI_RDATA  out  C_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RLAST  out  1  final beat.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data handshake.
- S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID  in  as for AR / S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  C_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte enables.
- S_AXI_WLAST  in  1 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1.
- S_AXI_BID  out  C_AXI_ID_WIDTH / S_AXI_BRESP  out  2 (always 00) / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1.

Behaviour:
- Reset values:
  - all VALID and READY outputs 0; RDATA 0; RLAST 0; RID and BID 0.
  - ram_array is NOT cleared by reset; bench preload survives reset.
- Word index = ADDR[log2(C_MEM_DEPTH)+log2(bytes)-1 : log2(bytes)]. Higher address bits are ignored, so addresses wrap modulo depth. Unaligned low bits are ignored.
- Read FSM:
  - R_IDLE: ARREADY=1; first cycle after RST falls is R_IDLE. On AR handshake, latch ID/index/len/burst, load latency counter, go to R_WAIT.
  - R_WAIT: ARREADY=0; counter decrements to 0, then go to R_BURST. With C_RD_LATENCY=0, R_WAIT is skipped and RVALID is asserted the cycle after the AR handshake.
  - R_BURST: RVALID=1, RDATA=ram_array[idx]. RDATA/RLAST/RID are held stable while RREADY=0. On each beat handshake: INCR advances idx by 1 (wrapping); FIXED holds idx; WRAP (2'b10) and reserved (2'b11) are treated as INCR. RLAST=1 on beat len. After the last handshake go to R_IDLE.
  - Single outstanding read; ARREADY stays 0 until R_IDLE.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB into ram_array[idx], then advances idx as for reads. WLAST ends the phase; the beat count is not checked against AWLEN.
  - W_LAT: wait C_WR_LATENCY cycles.
  - W_RESP: BVALID=1 until BREADY, then go to W_IDLE.
  - W data arriving before AW is not accepted: WREADY=0 outside W_DATA.
- Read and write FSMs are fully independent. On a same-cycle write commit and read beat to the same word, the read returns the old value; the new value is visible from the next beat.
- RST during a transaction:
  - both FSMs go to idle next cycle; VALIDs drop;
  - the in-flight burst is abandoned;
  - words already written stay written.

Optional Feature:
- Macro AXI_SLV_RANDOM_STALL_EN.
- Defined:
  - a 16-bit LFSR (seed 16'hACE1, reloaded on RST) advances every cycle;
  - when LFSR[0]=1 the block suppresses ARREADY, AWREADY and WREADY, and delays RVALID assertion for the next beat;
  - an asserted RVALID is never withdrawn before its handshake;
  - data and ordering are unchanged; only timing varies.
- Undefined: the LFSR and its logic are absent; timing is exactly as in Behaviour.

Test Plan:
- Preload ram_array[0..3] = 32'h00000093, 32'h3E800093, 32'h0, 32'h7D008113; then ARADDR=0, ARLEN=3, INCR, RREADY=1, C_RD_LATENCY=2 -> first RVALID 3 cycles after the AR handshake; 4 beats in order; RLAST only on beat 3; RID echoes ARID.
- AWADDR=0x10, AWLEN=0, WDATA=32'hDEADBEEF, WSTRB=4'b0101, ram_array[4]=0 -> ram_array[4]=32'h00AD00EF; BVALID exactly C_WR_LATENCY+1 cycles after WLAST; BRESP=00.
- Read with RREADY held low 5 cycles mid-burst -> RDATA/RLAST stable throughout the stall; no beat lost or duplicated.
- ARADDR=(C_MEM_DEPTH-1)*4, ARLEN=1, INCR -> beats return ram_array[2047] then ram_array[0].
- FIXED burst, ARLEN=2 at word 5 -> three beats, all ram_array[5].
- RST pulsed during R_BURST beat 1 -> RVALID=0 next cycle; ARREADY=1 the cycle after RST falls; ram_array contents unchanged.

Source files
------------

// File: rtl/axi_slave_mem_model.sv
// axi_slave_mem_model
//   AXI4 slave memory model for core-level benches. One read and one write
//   channel set, each driven by its own independent FSM. Storage is the word
//   array ram_array, which the bench may preload hierarchically; reset never
//   clears it.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   S_AXI_AR* / S_AXI_R*     read address / read data channels
//   S_AXI_AW* / S_AXI_W*     write address / write data channels
//   S_AXI_B*                 write response channel
//
// Build option
//   AXI_SLV_RANDOM_STALL_EN  when defined, a 16-bit LFSR randomly withholds
//                            ARREADY/AWREADY/WREADY and delays RVALID.
//                            Data and ordering are unchanged.
//
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for a read address
//   R_WAIT  | read latency countdown
//   R_BURST | RVALID high, presenting beats until the RLAST handshake
//
// Write FSM
//   state   | meaning
//   W_IDLE  | AWREADY high, waiting for a write address
//   W_DATA  | WREADY high, committing beats until WLAST
//   W_LAT   | write latency countdown
//   W_RESP  | BVALID high until BREADY
module axi_slave_mem_model #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28,
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_MEM_DEPTH      = 2048,
  parameter int C_RD_LATENCY     = 2,
  parameter int C_WR_LATENCY     = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(C_MEM_DEPTH);
  // Counters are loaded with latency-1: entering the wait state already costs one cycle.
  localparam logic [3:0] RD_CNT_INIT = 4'(C_RD_LATENCY == 0 ? 0 : C_RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(C_WR_LATENCY == 0 ? 0 : C_WR_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_t;

  logic [C_AXI_DATA_WIDTH-1:0] ram_array [C_MEM_DEPTH];

  r_state_t          r_state, r_state_nxt;
  w_state_t          w_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt;
  logic [IDX_W-1:0]  r_idx, r_idx_nxt, w_idx, ar_idx, aw_idx;
  logic [7:0]        r_len, r_beat;
  logic              r_fixed, w_fixed;
  logic              ar_hs, r_hs, aw_hs, w_hs;
  logic              stall;

  assign ar_idx    = S_AXI_ARADDR[IDX_W+BYTE_W-1 -: IDX_W];
  assign aw_idx    = S_AXI_AWADDR[IDX_W+BYTE_W-1 -: IDX_W];
  assign r_idx_nxt = r_fixed ? r_idx : r_idx + IDX_W'(1);

`ifdef AXI_SLV_RANDOM_STALL_EN
  logic [15:0] lfsr;
  logic        rv_armed;

  always_ff @(posedge CLK) begin
    if (RST) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];

  // Once RVALID is shown it must stay up until accepted, regardless of the LFSR.
  always_ff @(posedge CLK) begin
    if (RST) rv_armed <= 1'b0;
    else     rv_armed <= S_AXI_RVALID && !S_AXI_RREADY;
  end
  assign S_AXI_RVALID = (r_state == R_BURST) && (rv_armed || !stall);
`else
  assign stall        = 1'b0;
  assign S_AXI_RVALID = (r_state == R_BURST);
`endif

  // Readies are masked during RST so nothing is accepted in the reset cycle.
  assign S_AXI_ARREADY = (r_state == R_IDLE) && !RST && !stall;
  assign S_AXI_AWREADY = (w_state == W_IDLE) && !RST && !stall;
  assign S_AXI_WREADY  = (w_state == W_DATA) && !RST && !stall;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_BRESP   = 2'b00;

  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

  // Address bits outside the word index and AWLEN are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_ARADDR, S_AXI_AWADDR, S_AXI_AWLEN};

  // ---------------- read channel ----------------
  always_ff @(posedge CLK) begin
    if (RST) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = (C_RD_LATENCY == 0) ? R_BURST : R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_state_nxt = R_BURST;
      R_BURST: if (r_hs && S_AXI_RLAST) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // RDATA is registered when a beat is loaded, so it stays stable through
  // RREADY stalls and a same-edge write to that word is seen on the next beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_len       <= 8'd0;
      r_beat      <= 8'd0;
      r_fixed     <= 1'b0;
      S_AXI_RID   <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RLAST <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          S_AXI_RID <= S_AXI_ARID;
          r_len     <= S_AXI_ARLEN;
          r_fixed   <= (S_AXI_ARBURST == 2'b00);
          r_beat    <= 8'd0;
          r_cnt     <= RD_CNT_INIT;
          r_idx     <= ar_idx;
          if (C_RD_LATENCY == 0) begin
            S_AXI_RDATA <= ram_array[ar_idx];
            S_AXI_RLAST <= (S_AXI_ARLEN == 8'd0);
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            S_AXI_RDATA <= ram_array[r_idx];
            S_AXI_RLAST <= (r_len == 8'd0);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_BURST: if (r_hs) begin
          if (S_AXI_RLAST) begin
            S_AXI_RLAST <= 1'b0;
          end else begin
            r_idx       <= r_idx_nxt;
            S_AXI_RDATA <= ram_array[r_idx_nxt];
            r_beat      <= r_beat + 8'd1;
            S_AXI_RLAST <= (r_beat + 8'd1 == r_len);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write channel ----------------
  always_ff @(posedge CLK) begin
    if (RST) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && S_AXI_WLAST) w_state_nxt = (C_WR_LATENCY == 0) ? W_RESP : W_LAT;
      W_LAT:   if (w_cnt == 4'd0) w_state_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_cnt     <= 4'd0;
      w_idx     <= '0;
      w_fixed   <= 1'b0;
      S_AXI_BID <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          S_AXI_BID <= S_AXI_AWID;
          w_idx     <= aw_idx;
          w_fixed   <= (S_AXI_AWBURST == 2'b00);
        end
        W_DATA: if (w_hs) begin
          if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
          if (S_AXI_WLAST) w_cnt <= WR_CNT_INIT;
        end
        W_LAT: if (w_cnt != 4'd0) w_cnt <= w_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Storage has no reset so bench preloads and completed writes survive RST.
  always_ff @(posedge CLK) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) ram_array[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_model.sv
module tb_axi_slave_mem_model;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [0:0]  S_AXI_ARID = '0;
  logic [27:0] S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [1:0]  S_AXI_ARBURST = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [0:0]  S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [0:0]  S_AXI_AWID = '0;
  logic [27:0] S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [1:0]  S_AXI_AWBURST = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [0:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;

  int total = 0;
  int bad   = 0;

  axi_slave_mem_model dut (
    .CLK(CLK), .RST(RST),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issues one AR handshake and returns the number of cycles until RVALID
  // (cycle 1 is the one right after the handshake edge); bounded at 40.
  task automatic start_read(input logic [27:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic id, output int cyc);
    S_AXI_ARADDR  = addr;
    S_AXI_ARLEN   = len;
    S_AXI_ARBURST = burst;
    S_AXI_ARID    = id;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    cyc = 1;
    while (!S_AXI_RVALID && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    total++; if (S_AXI_ARREADY !== 1'b0) begin bad++; $display("FAIL reset_arready got=%b want=0", S_AXI_ARREADY); end
    total++; if (S_AXI_AWREADY !== 1'b0) begin bad++; $display("FAIL reset_awready got=%b want=0", S_AXI_AWREADY); end
    total++; if (S_AXI_WREADY  !== 1'b0) begin bad++; $display("FAIL reset_wready got=%b want=0", S_AXI_WREADY); end
    total++; if (S_AXI_RVALID  !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", S_AXI_RVALID); end
    total++; if (S_AXI_BVALID  !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%b want=0", S_AXI_BVALID); end
    total++; if (S_AXI_RDATA   !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", S_AXI_RDATA); end
    total++; if (S_AXI_RLAST   !== 1'b0) begin bad++; $display("FAIL reset_rlast got=%b want=0", S_AXI_RLAST); end
    total++; if (S_AXI_RID     !== 1'b0) begin bad++; $display("FAIL reset_rid got=%b want=0", S_AXI_RID); end
    total++; if (S_AXI_BID     !== 1'b0) begin bad++; $display("FAIL reset_bid got=%b want=0", S_AXI_BID); end
    RST = 1'b0;
    tick();
    total++; if (S_AXI_ARREADY !== 1'b1) begin bad++; $display("FAIL post_reset_arready got=%b want=1", S_AXI_ARREADY); end
    total++; if (S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL post_reset_awready got=%b want=1", S_AXI_AWREADY); end
  endtask

  task automatic test_incr_read();
    logic [31:0] exp [4] = '{32'h00000093, 32'h3E800093, 32'h00000000, 32'h7D008113};
    int cyc;
    S_AXI_RREADY = 1'b1;
    start_read(28'h0, 8'd3, 2'b01, 1'b1, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL incr_latency got=%0d want=3", cyc); end
    for (int b = 0; b < 4; b++) begin
      total++; if (S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL incr_rvalid beat=%0d got=%b want=1", b, S_AXI_RVALID); end
      total++; if (S_AXI_RDATA !== exp[b]) begin bad++; $display("FAIL incr_rdata beat=%0d got=%h want=%h", b, S_AXI_RDATA, exp[b]); end
      total++; if (S_AXI_RLAST !== (b == 3)) begin bad++; $display("FAIL incr_rlast beat=%0d got=%b want=%b", b, S_AXI_RLAST, (b == 3)); end
      total++; if (S_AXI_RID !== 1'b1) begin bad++; $display("FAIL incr_rid beat=%0d got=%b want=1", b, S_AXI_RID); end
      total++; if (S_AXI_RRESP !== 2'b00) begin bad++; $display("FAIL incr_rresp beat=%0d got=%b want=00", b, S_AXI_RRESP); end
      tick();
    end
    total++; if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL incr_end_rvalid got=%b want=0", S_AXI_RVALID); end
    total++; if (S_AXI_ARREADY !== 1'b1) begin bad++; $display("FAIL incr_end_arready got=%b want=1", S_AXI_ARREADY); end
  endtask

  task automatic test_write_strobe();
    int cyc;
    S_AXI_AWADDR  = 28'h10;
    S_AXI_AWLEN   = 8'd0;
    S_AXI_AWBURST = 2'b01;
    S_AXI_AWID    = 1'b1;
    S_AXI_AWVALID = 1'b1;
    // W before AW must not be accepted.
    S_AXI_WDATA   = 32'hFFFFFFFF;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_WLAST   = 1'b1;
    S_AXI_WVALID  = 1'b1;
    total++; if (S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL w_before_aw_wready got=%b want=0", S_AXI_WREADY); end
    tick();
    S_AXI_AWVALID = 1'b0;
    total++; if (dut.ram_array[4] !== 32'h0) begin bad++; $display("FAIL w_before_aw_ram got=%h want=0", dut.ram_array[4]); end
    S_AXI_WDATA = 32'hDEADBEEF;
    S_AXI_WSTRB = 4'b0101;
    total++; if (S_AXI_WREADY !== 1'b1) begin bad++; $display("FAIL wdata_wready got=%b want=1", S_AXI_WREADY); end
    tick();
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    total++; if (S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL after_wlast_wready got=%b want=0", S_AXI_WREADY); end
    cyc = 1;
    while (!S_AXI_BVALID && cyc < 40) begin
      tick();
      cyc++;
    end
    total++; if (cyc !== 2) begin bad++; $display("FAIL bvalid_latency got=%0d want=2", cyc); end
    total++; if (S_AXI_BRESP !== 2'b00) begin bad++; $display("FAIL bresp got=%b want=00", S_AXI_BRESP); end
    total++; if (S_AXI_BID !== 1'b1) begin bad++; $display("FAIL bid got=%b want=1", S_AXI_BID); end
    total++; if (dut.ram_array[4] !== 32'h00AD00EF) begin bad++; $display("FAIL strobe_ram got=%h want=00ad00ef", dut.ram_array[4]); end
    repeat (2) tick();
    total++; if (S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL bvalid_hold got=%b want=1", S_AXI_BVALID); end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    total++; if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL bvalid_drop got=%b want=0", S_AXI_BVALID); end
    total++; if (S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL w_end_awready got=%b want=1", S_AXI_AWREADY); end
  endtask

  task automatic test_read_stall();
    logic [31:0] exp [4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    int cyc;
    S_AXI_RREADY = 1'b1;
    start_read(28'h20, 8'd3, 2'b01, 1'b0, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL stall_latency got=%0d want=3", cyc); end
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        S_AXI_RREADY = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          total++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp[2] || S_AXI_RLAST !== 1'b0)
            begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b want=1/%h/0", s, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, exp[2]); end
        end
        S_AXI_RREADY = 1'b1;
      end
      total++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp[b])
        begin bad++; $display("FAIL stall_beat beat=%0d got=%b/%h want=1/%h", b, S_AXI_RVALID, S_AXI_RDATA, exp[b]); end
      total++; if (S_AXI_RLAST !== (b == 3)) begin bad++; $display("FAIL stall_rlast beat=%0d got=%b want=%b", b, S_AXI_RLAST, (b == 3)); end
      tick();
    end
    total++; if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL stall_extra_beat got=%b want=0", S_AXI_RVALID); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [2] = '{32'hCAFE0001, 32'h00000093};
    int cyc;
    S_AXI_RREADY = 1'b1;
    start_read(28'h1FFC, 8'd1, 2'b01, 1'b0, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL wrap_latency got=%0d want=3", cyc); end
    for (int b = 0; b < 2; b++) begin
      total++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp[b] || S_AXI_RLAST !== (b == 1))
        begin bad++; $display("FAIL wrap_beat beat=%0d got=%b/%h/%b want=1/%h/%b", b, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, exp[b], (b == 1)); end
      tick();
    end
  endtask

  task automatic test_fixed();
    int cyc;
    S_AXI_RREADY = 1'b1;
    start_read(28'h14, 8'd2, 2'b00, 1'b1, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL fixed_latency got=%0d want=3", cyc); end
    for (int b = 0; b < 3; b++) begin
      total++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h55AA0005 || S_AXI_RLAST !== (b == 2))
        begin bad++; $display("FAIL fixed_beat beat=%0d got=%b/%h/%b want=1/55aa0005/%b", b, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, (b == 2)); end
      tick();
    end
    total++; if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL fixed_extra_beat got=%b want=0", S_AXI_RVALID); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [2] = '{32'h11112222, 32'h33334444};
    int cyc;
    S_AXI_AWADDR  = 28'h40;
    S_AXI_AWLEN   = 8'd1;
    S_AXI_AWBURST = 2'b01;
    S_AXI_AWID    = 1'b0;
    S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_WVALID  = 1'b1;
    for (int b = 0; b < 2; b++) begin
      S_AXI_WDATA = exp[b];
      S_AXI_WLAST = (b == 1);
      tick();
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    cyc = 1;
    while (!S_AXI_BVALID && cyc < 40) begin
      tick();
      cyc++;
    end
    total++; if (cyc !== 2) begin bad++; $display("FAIL b2b_bvalid_latency got=%0d want=2", cyc); end
    total++; if (S_AXI_BID !== 1'b0) begin bad++; $display("FAIL b2b_bid got=%b want=0", S_AXI_BID); end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b1;
    start_read(28'h40, 8'd1, 2'b01, 1'b0, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL b2b_read_latency got=%0d want=3", cyc); end
    for (int b = 0; b < 2; b++) begin
      total++; if (S_AXI_RDATA !== exp[b] || S_AXI_RLAST !== (b == 1))
        begin bad++; $display("FAIL b2b_readback beat=%0d got=%h/%b want=%h/%b", b, S_AXI_RDATA, S_AXI_RLAST, exp[b], (b == 1)); end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    S_AXI_RREADY = 1'b1;
    start_read(28'h30, 8'd3, 2'b01, 1'b1, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL rst_mid_latency got=%0d want=3", cyc); end
    tick();
    total++; if (S_AXI_RDATA !== 32'hB1B1B1B1) begin bad++; $display("FAIL rst_mid_beat1 got=%h want=b1b1b1b1", S_AXI_RDATA); end
    RST = 1'b1;
    tick();
    total++; if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL rst_mid_rvalid got=%b want=0", S_AXI_RVALID); end
    total++; if (S_AXI_ARREADY !== 1'b0) begin bad++; $display("FAIL rst_mid_arready_in_rst got=%b want=0", S_AXI_ARREADY); end
    RST = 1'b0;
    tick();
    total++; if (S_AXI_ARREADY !== 1'b1) begin bad++; $display("FAIL rst_mid_arready got=%b want=1", S_AXI_ARREADY); end
    total++; if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL rst_mid_rvalid_after got=%b want=0", S_AXI_RVALID); end
    total++; if (dut.ram_array[12] !== 32'hB0B0B0B0 || dut.ram_array[13] !== 32'hB1B1B1B1)
      begin bad++; $display("FAIL rst_mid_ram got=%h/%h want=b0b0b0b0/b1b1b1b1", dut.ram_array[12], dut.ram_array[13]); end
    total++; if (dut.ram_array[4] !== 32'h00AD00EF) begin bad++; $display("FAIL rst_mid_written_word got=%h want=00ad00ef", dut.ram_array[4]); end
  endtask

  initial begin
    dut.ram_array[0]    = 32'h00000093;
    dut.ram_array[1]    = 32'h3E800093;
    dut.ram_array[2]    = 32'h00000000;
    dut.ram_array[3]    = 32'h7D008113;
    dut.ram_array[4]    = 32'h00000000;
    dut.ram_array[5]    = 32'h55AA0005;
    dut.ram_array[8]    = 32'hA0A0A0A0;
    dut.ram_array[9]    = 32'hA1A1A1A1;
    dut.ram_array[10]   = 32'hA2A2A2A2;
    dut.ram_array[11]   = 32'hA3A3A3A3;
    dut.ram_array[12]   = 32'hB0B0B0B0;
    dut.ram_array[13]   = 32'hB1B1B1B1;
    dut.ram_array[14]   = 32'hB2B2B2B2;
    dut.ram_array[15]   = 32'hB3B3B3B3;
    dut.ram_array[2047] = 32'hCAFE0001;
    test_reset();
    test_incr_read();
    test_write_strobe();
    test_read_stall();
    test_wrap();
    test_fixed();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "watchdog");
  end

endmodule
